ram_loader: RTL

- Upstream stage for the 32x8 single-port RAM and its scroll/display logic.
- Turns two raw push-buttons (WRITE key, CLEAR key) and an 8-bit switch bank into clean one-cycle RAM write transactions: DATA, ADDRESS and WE, all driven synchronously.
- Keeps an auto-incrementing write pointer, so the user fills RAM sequentially without setting address switches.
- Can also sweep-clear the whole RAM to zero.

---
 rtl/lab8_pkg.sv | 21 ++
 rtl/key_debounce.sv | 58 +++++
 rtl/ram_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lab8_pkg.sv
// Shared definitions for the RAM loader and the RAM/scroll top.
// Holds the loader state encoding and board-level constants.
package lab8_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 8;
  localparam int unsigned CLK_HZ     = 50_000_000;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_e;

  function automatic int unsigned deb_cnt_w(
    input int unsigned n
  );
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter
// and a one-cycle pulse on the debounced released->pressed edge.
module key_debounce
  import lab8_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d  = ~key_n;
    sync_d  = meta_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Count only while the synced level disagrees with the accepted one
    if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
        press_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/ram_loader.sv
// Turns debounced WRITE/CLEAR keys into single-cycle RAM writes with
// an auto-incrementing pointer, plus a full-depth clear sweep.
module ram_loader
  import lab8_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAM_ADDR_W,
  parameter int unsigned DATA_W     = RAM_DATA_W,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              KEY_WR_N,
  input  logic              KEY_CLR_N,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] DATA,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic              WE,
  output logic [ADDR_W-1:0] PTR,
  output logic              WRAPPED,
  output logic              BUSY
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic wr_press;
  logic clr_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_wr_key (
    .clk   (CLK),
    .rst_n (RESET_N),
    .key_n (KEY_WR_N),
    .press (wr_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_key (
    .clk   (CLK),
    .rst_n (RESET_N),
    .key_n (KEY_CLR_N),
    .press (clr_press)
  );

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              we_q, we_d;
  logic              wrapped_q, wrapped_d;
  logic              busy_q, busy_d;

  // Outputs are registered, so each branch sets what the next state shows
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    sweep_d   = sweep_q;
    wrapped_d = wrapped_q;
    we_d      = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_press) begin
          state_d = CLEAR;
          sweep_d = '0;
          addr_d  = '0;
          data_d  = '0;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end else if (wr_press) begin
          state_d = WRITE;
          addr_d  = ptr_q;
          data_d  = SW;
          we_d    = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
        ptr_d   = ptr_q + ADDR_ONE;
        if (ptr_q == ADDR_MAX) begin
          wrapped_d = 1'b1;
        end
      end
      CLEAR: begin
        if (sweep_q == ADDR_MAX) begin
          state_d   = IDLE;
          ptr_d     = '0;
          wrapped_d = 1'b0;
        end else begin
          sweep_d = sweep_q + ADDR_ONE;
          addr_d  = sweep_q + ADDR_ONE;
          data_d  = '0;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      data_q    <= '0;
      addr_q    <= '0;
      ptr_q     <= '0;
      sweep_q   <= '0;
      we_q      <= 1'b0;
      wrapped_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      sweep_q   <= sweep_d;
      we_q      <= we_d;
      wrapped_q <= wrapped_d;
      busy_q    <= busy_d;
    end
  end

  assign DATA    = data_q;
  assign ADDRESS = addr_q;
  assign WE      = we_q;
  assign PTR     = ptr_q;
  assign WRAPPED = wrapped_q;
  assign BUSY    = busy_q;

endmodule
